mpx_irq_ctrl: RTL
=================

MPX_IRQ_CTRL -- requirements
Module: mpx_irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 11, giving the number of interrupt sources (1..16).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port irq_src_i, input, NUM_IRQ bits: peripheral interrupt lines, synchronous to clk_i.
REQ-005 The block SHALL have port cfg_rd_i, input, 1 bit: register read request, one-cycle pulse.
REQ-006 The block SHALL have port cfg_wr_i, input, 1 bit: register write request, one-cycle pulse.
REQ-007 The block SHALL have port cfg_addr_i, input, 4 bits: byte address; bits [3:2] select the word.
REQ-008 The block SHALL have port cfg_wdata_i, input, 32 bits: write data.
REQ-009 The block SHALL have port cfg_rdata_o, output, 32 bits: read data, valid while cfg_ack_o is high.
REQ-010 The block SHALL have port cfg_ack_o, output, 1 bit: access complete.
REQ-011 The block SHALL have port ext_intr_o, output, 6 bits: drives the CPU ext_intr_i; bit 0 = masked pending, bits 5:1 = 0.

Function
REQ-012 Register map: word 0 (0x0) I_STAT; word 1 (0x4) I_MASK; words 2-3 unmapped.
REQ-013 Edge detect: a prev_q register samples irq_src_i every cycle; a bit with irq_src_i=1 and prev_q=0 is a rising edge.
REQ-014 A rising edge SHALL set the corresponding I_STAT bit on the same clock edge that updates prev_q, so I_STAT shows it 1 cycle after the source rises.
REQ-015 A level held high SHALL NOT re-set a cleared I_STAT bit; only a new 0->1 transition sets it.
REQ-016 I_STAT write: I_STAT_next = (I_STAT & cfg_wdata_i[NUM_IRQ-1:0]) | edges; writing 0 acknowledges a bit and writing 1 leaves it unchanged.
REQ-017 Simultaneous edge and acknowledge on the same bit: set wins, the bit stays 1.
REQ-018 I_MASK write: I_MASK = cfg_wdata_i[NUM_IRQ-1:0].
REQ-019 Reads return {zero-extend, reg[NUM_IRQ-1:0]}; bits 31:NUM_IRQ SHALL always read 0.
REQ-020 Unmapped words SHALL read 0, ignore writes, and still ack.
REQ-021 Access handshake: cfg_ack_o SHALL pulse high exactly 1 cycle after the cycle in which cfg_rd_i or cfg_wr_i is high; fixed latency 1, no stalls, and back-to-back requests every cycle are accepted.
REQ-022 cfg_rdata_o SHALL be registered and hold the value of the addressed register as it was before the requesting clock edge; it is 0 when cfg_ack_o is low or the access was a write-only access.
REQ-023 cfg_rd_i and cfg_wr_i both high: the write is performed; cfg_rdata_o returns the pre-write value; a single ack is issued.
REQ-024 ext_intr_o[0] SHALL equal |(I_STAT & I_MASK) computed from registered state, with no combinational path from any input.
REQ-025 Mask change SHALL affect ext_intr_o[0] 1 cycle after the write request; I_STAT bits SHALL latch regardless of mask.

Reset
REQ-026 On rst_i=0, asynchronously: I_STAT=0, I_MASK=0, prev_q=0, cfg_ack_o=0, cfg_rdata_o=0, ext_intr_o=0.
REQ-027 A source already high when reset releases SHALL be treated as a rising edge on the first clock after release.
REQ-028 Reset asserted mid-access SHALL drop any pending ack; no ack SHALL be issued after release for a request made before reset.

Verification
REQ-029 Edge and mask: I_MASK=0x001, pulse irq_src_i[0] for 1 cycle -> I_STAT=0x001 next cycle, ext_intr_o=6'b000001; write I_STAT=0x7FE -> ext_intr_o=0 one cycle later.
REQ-030 Level hold: irq_src_i[3] held high, ack bit 3 (write 0x7F7) -> I_STAT[3] stays 0 until irq_src_i[3] falls and rises again.
REQ-031 Collision: edge on bit 5 in the same cycle as an I_STAT write of 0x000 -> I_STAT reads 0x020.
REQ-032 Handshake: reads on consecutive cycles of 0x0, 0x4, 0x8, 0xC -> four acks on consecutive cycles with data I_STAT, I_MASK, 0, 0; a write of 0xFFFFFFFF to I_MASK reads back 0x000007FF.
REQ-033 Reset: assert rst_i low asynchronously with I_STAT=0x3FF and cfg_rd_i high -> all outputs 0 immediately; after release with irq_src_i[2]=1 -> I_STAT=0x004 after 1 cycle.

Source files
------------

// File: rtl/mpx_irq_ctrl_if.sv
// Register access bus of the interrupt controller: one-cycle request pulses,
// fixed single-cycle acknowledge with registered read data.
interface mpx_irq_ctrl_if;
    logic        cfg_rd_i;
    logic        cfg_wr_i;
    logic [3:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        cfg_ack_o;

    modport master (
        output cfg_rd_i,
        output cfg_wr_i,
        output cfg_addr_i,
        output cfg_wdata_i,
        input  cfg_rdata_o,
        input  cfg_ack_o
    );

    modport slave (
        input  cfg_rd_i,
        input  cfg_wr_i,
        input  cfg_addr_i,
        input  cfg_wdata_i,
        output cfg_rdata_o,
        output cfg_ack_o
    );
endinterface

// File: rtl/mpx_irq_ctrl.sv
// Edge-triggered interrupt controller: latches rising edges of the sources into
// I_STAT, gates them with I_MASK and raises a single CPU interrupt line.
module mpx_irq_ctrl #(
    parameter int NUM_IRQ = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    mpx_irq_ctrl_if.slave      cfg,
    output logic [5:0]         ext_intr_o
);

    localparam logic [1:0] WORD_STAT = 2'd0;
    localparam logic [1:0] WORD_MASK = 2'd1;

    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_stat;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_ack;
    logic [31:0]        r_rdata;
    logic               r_irq;

    logic [NUM_IRQ-1:0] w_edges;
    logic [NUM_IRQ-1:0] w_stat_next;
    logic [NUM_IRQ-1:0] w_mask_next;
    logic [31:0]        w_rd_sel;
    logic [1:0]         w_word;
    logic               w_unused_bits;

    function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    assign w_word        = cfg.cfg_addr_i[3:2];
    assign w_edges       = irq_src_i & ~r_prev;
    assign w_unused_bits = ^{cfg.cfg_wdata_i[31:NUM_IRQ], cfg.cfg_addr_i[1:0]};

    // Next-state of the status and mask registers; a new edge always beats an acknowledge.
    always_comb begin
        w_stat_next = r_stat | w_edges;
        w_mask_next = r_mask;
        if (cfg.cfg_wr_i) begin
            case (w_word)
                WORD_STAT: w_stat_next = (r_stat & cfg.cfg_wdata_i[NUM_IRQ-1:0]) | w_edges;
                WORD_MASK: w_mask_next = cfg.cfg_wdata_i[NUM_IRQ-1:0];
                default: begin
                    w_stat_next = r_stat | w_edges;
                    w_mask_next = r_mask;
                end
            endcase
        end else begin
            w_stat_next = r_stat | w_edges;
            w_mask_next = r_mask;
        end
    end

    // Read mux over pre-edge register contents; unmapped words return zero.
    always_comb begin
        w_rd_sel = 32'd0;
        case (w_word)
            WORD_STAT: w_rd_sel = zext(r_stat);
            WORD_MASK: w_rd_sel = zext(r_mask);
            default:   w_rd_sel = 32'd0;
        endcase
    end

    // Register state; the interrupt flop is fed from next-state so it tracks I_STAT/I_MASK with no lag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prev  <= '0;
            r_stat  <= '0;
            r_mask  <= '0;
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
            r_irq   <= 1'b0;
        end else begin
            r_prev  <= irq_src_i;
            r_stat  <= w_stat_next;
            r_mask  <= w_mask_next;
            r_ack   <= cfg.cfg_rd_i | cfg.cfg_wr_i;
            r_rdata <= cfg.cfg_rd_i ? w_rd_sel : 32'd0;
            r_irq   <= |(w_stat_next & w_mask_next);
        end
    end

    assign cfg.cfg_ack_o   = r_ack;
    assign cfg.cfg_rdata_o = r_rdata;
    assign ext_intr_o      = {5'b00000, r_irq};

endmodule
